// File: rtl/angle_sensor_scheduler_if.sv
// SPI-side bundle between the angle-sensor scheduler (master modport)
// and the SPI master / sensor chip-select fabric (slave modport).
interface angle_sensor_scheduler_if #(
  parameter int NUMBER_OF_MOTORS = 6
) ();
  logic                        spi_start;
  logic [15:0]                 spi_tx_data;
  logic                        spi_done;
  logic [15:0]                 spi_rx_data;
  logic [NUMBER_OF_MOTORS-1:0] ss_n;

  modport master (
    output spi_start,
    output spi_tx_data,
    output ss_n,
    input  spi_done,
    input  spi_rx_data
  );

  modport slave (
    input  spi_start,
    input  spi_tx_data,
    input  ss_n,
    output spi_done,
    output spi_rx_data
  );
endinterface

// File: rtl/angle_sensor_scheduler.sv
// Frame-based owner of the shared A1339 SPI bus: once per frame it polls every
// enabled sensor in index order and emits a per-motor update strobe per good reply.
module angle_sensor_scheduler #(
  parameter int          NUMBER_OF_MOTORS = 6,
  parameter int          CLOCK_SPEED_HZ   = 50_000_000,
  parameter int          UPDATE_RATE_HZ   = 1000,
  parameter logic [15:0] READ_CMD         = 16'h2000,
  parameter int          SETUP_CYCLES     = 4,
  parameter int          GAP_CYCLES       = 4,
  parameter int          TIMEOUT_CYCLES   = 1024
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUMBER_OF_MOTORS-1:0] enable_mask,
  input  logic                        clear_errors,
  angle_sensor_scheduler_if.master    spi,
  output logic                        sample_valid,
  output logic [7:0]                  sample_index,
  output logic [11:0]                 sample_angle,
  output logic [NUMBER_OF_MOTORS-1:0] cycle,
  output logic [NUMBER_OF_MOTORS-1:0] error_flags,
  output logic                        frame_overrun,
  output logic                        busy
);
  localparam int N      = NUMBER_OF_MOTORS;
  localparam int PERIOD = CLOCK_SPEED_HZ / UPDATE_RATE_HZ;
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  // Shared setup/wait/gap timer; covers delays up to 65536 cycles.
  localparam int TMR_W  = 16;

  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ZERO     = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] SETUP_LAST   = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST     = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [N-1:0]     ALL_HIGH     = {N{1'b1}};
  localparam logic [N-1:0]     ALL_LOW      = {N{1'b0}};

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SELECT   = 3'd1;
  localparam logic [2:0] S_START    = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_DESELECT = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;

  function automatic logic reply_good(input logic [15:0] w);
    return ((^w) == 1'b0) && (w[14] == 1'b0);
  endfunction

  function automatic logic [N-1:0] one_hot(input logic [7:0] i);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) begin
      r[k] = (8'(k) == i);
    end
    return r;
  endfunction

  // Returns {found, index} of the lowest set bit of m at or above lo.
  function automatic logic [8:0] find_from(input logic [N-1:0] m, input logic [8:0] lo);
    logic [8:0] r;
    r = 9'h000;
    for (int k = N - 1; k >= 0; k--) begin
      if (m[k] && (9'(k) >= lo)) begin
        r = {1'b1, 8'(k)};
      end
    end
    return r;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       idx_q, idx_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [N-1:0]     ss_n_q, ss_n_d;
  logic             spi_start_q, spi_start_d;
  logic [15:0]      tx_q;
  logic             sample_valid_q, sample_valid_d;
  logic [7:0]       sample_index_q, sample_index_d;
  logic [11:0]      sample_angle_q, sample_angle_d;
  logic [N-1:0]     cycle_q, cycle_d;
  logic [N-1:0]     err_q, err_d, err_set;
  logic             ovr_q, ovr_d, ovr_set;
  logic             busy_q, busy_d;
  logic             frame_tick;
  logic [8:0]       first_hit, next_hit;

  assign frame_tick = (cnt_q == CNT_LAST);
  assign first_hit  = find_from(enable_mask, 9'd0);
  assign next_hit   = find_from(mask_q, {1'b0, idx_q} + 9'd1);

  // Next-state logic for frame counter, sequencing FSM and all registered outputs.
  always_comb begin
    cnt_d          = frame_tick ? CNT_ZERO : cnt_q + CNT_W'(1);
    state_d        = state_q;
    timer_d        = timer_q;
    idx_d          = idx_q;
    mask_d         = mask_q;
    ss_n_d         = ss_n_q;
    spi_start_d    = 1'b0;
    sample_valid_d = 1'b0;
    sample_index_d = sample_index_q;
    sample_angle_d = sample_angle_q;
    cycle_d        = ALL_LOW;
    err_set        = ALL_LOW;
    ovr_set        = frame_tick && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          mask_d = enable_mask;
          if (first_hit[8]) begin
            idx_d   = first_hit[7:0];
            ss_n_d  = ~one_hot(first_hit[7:0]);
            timer_d = TMR_ZERO;
            state_d = S_SELECT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SELECT: begin
        if (timer_q == SETUP_LAST) begin
          timer_d     = TMR_ZERO;
          spi_start_d = 1'b1;
          state_d     = S_START;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_START: begin
        timer_d = TMR_ZERO;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (spi.spi_done) begin
          ss_n_d  = ALL_HIGH;
          timer_d = TMR_ZERO;
          state_d = S_DESELECT;
          if (reply_good(spi.spi_rx_data)) begin
            sample_valid_d = 1'b1;
            cycle_d        = one_hot(idx_q);
            sample_index_d = idx_q;
            sample_angle_d = spi.spi_rx_data[11:0];
          end else begin
            err_set = one_hot(idx_q);
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          ss_n_d  = ALL_HIGH;
          timer_d = TMR_ZERO;
          err_set = one_hot(idx_q);
          state_d = S_DESELECT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DESELECT: begin
        if (timer_q == GAP_LAST) begin
          timer_d = TMR_ZERO;
          state_d = S_NEXT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_NEXT: begin
        if (next_hit[8]) begin
          idx_d   = next_hit[7:0];
          ss_n_d  = ~one_hot(next_hit[7:0]);
          timer_d = TMR_ZERO;
          state_d = S_SELECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        ss_n_d  = ALL_HIGH;
        timer_d = TMR_ZERO;
        state_d = S_IDLE;
      end
    endcase

    // A flag raised in the same cycle as clear_errors stays raised.
    err_d  = (err_q & ~{N{clear_errors}}) | err_set;
    ovr_d  = (ovr_q & ~clear_errors) | ovr_set;
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      timer_q        <= TMR_ZERO;
      cnt_q          <= CNT_ZERO;
      idx_q          <= 8'd0;
      mask_q         <= ALL_LOW;
      ss_n_q         <= ALL_HIGH;
      spi_start_q    <= 1'b0;
      tx_q           <= READ_CMD;
      sample_valid_q <= 1'b0;
      sample_index_q <= 8'd0;
      sample_angle_q <= 12'd0;
      cycle_q        <= ALL_LOW;
      err_q          <= ALL_LOW;
      ovr_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      mask_q         <= mask_d;
      ss_n_q         <= ss_n_d;
      spi_start_q    <= spi_start_d;
      tx_q           <= READ_CMD;
      sample_valid_q <= sample_valid_d;
      sample_index_q <= sample_index_d;
      sample_angle_q <= sample_angle_d;
      cycle_q        <= cycle_d;
      err_q          <= err_d;
      ovr_q          <= ovr_d;
      busy_q         <= busy_d;
    end
  end

  assign spi.spi_start   = spi_start_q;
  assign spi.spi_tx_data = tx_q;
  assign spi.ss_n        = ss_n_q;
  assign sample_valid    = sample_valid_q;
  assign sample_index    = sample_index_q;
  assign sample_angle    = sample_angle_q;
  assign cycle           = cycle_q;
  assign error_flags     = err_q;
  assign frame_overrun   = ovr_q;
  assign busy            = busy_q;
endmodule

// File: doc/angle_sensor_scheduler.md
# angle_sensor_scheduler

Frame-based sequencer that owns the shared A1339 angle-sensor SPI bus on the MSJ platform. At a fixed update rate it walks the enabled sensors in index order. For each sensor it asserts that sensor's slave select, starts one 16-bit SPI transfer on the SPI master, and checks the reply. Each good sample is forwarded together with a one-cycle per-motor `cycle` strobe that drives that motor's PID controller update. Sits between the register/PID layer and the SPI master, replacing free-running sensor polling.

## Interface
- NUMBER_OF_MOTORS, 6, number of sensors/slave selects (1..16)
- CLOCK_SPEED_HZ, 50_000_000, clock frequency
- UPDATE_RATE_HZ, 1000, frame rate; PERIOD = CLOCK_SPEED_HZ/UPDATE_RATE_HZ cycles
- READ_CMD, 16'h2000, word transmitted to each sensor
- SETUP_CYCLES, 4, cycles from ss_n low to spi_start
- GAP_CYCLES, 4, cycles ss_n held high between sensors
- TIMEOUT_CYCLES, 1024, max cycles waiting for spi_done
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable_mask  in  NUMBER_OF_MOTORS  sensors to poll; latched at frame start
- clear_errors  in  1  one-cycle pulse, clears error_flags and frame_overrun
- spi_start  out  1  one-cycle pulse, starts transfer of spi_tx_data
- spi_tx_data  out  16  always READ_CMD
- spi_done  in  1  one-cycle pulse, spi_rx_data valid this cycle
- spi_rx_data  in  16  received word
- ss_n  out  NUMBER_OF_MOTORS  active-low slave selects, at most one low
- sample_valid  out  1  one-cycle pulse, good sample
- sample_index  out  8  sensor index of sample
- sample_angle  out  12  spi_rx_data[11:0] of good sample
- cycle  out  NUMBER_OF_MOTORS  one-hot one-cycle update strobe, coincident with sample_valid
- error_flags  out  NUMBER_OF_MOTORS  sticky per-sensor timeout/parity error
- frame_overrun  out  1  sticky, frame tick arrived while not IDLE
- busy  out  1  high in every state except IDLE

## Operation
- Frame counter: counts 0..PERIOD-1 and wraps. frame_tick is asserted when the count equals PERIOD-1. The counter runs regardless of FSM state.
- States:
  - IDLE: on frame_tick with a nonzero latched mask, go to SELECT using the lowest enabled index.
  - SELECT: ss_n[idx] low; wait SETUP_CYCLES.
  - START: spi_start=1 for exactly one cycle.
  - WAIT: stay until spi_done or TIMEOUT_CYCLES elapsed.
  - DESELECT: all ss_n high for GAP_CYCLES.
  - NEXT: go to the next higher enabled index in SELECT, or to IDLE if none remain (no wrap within a frame).
- Reply check: the reply is good when the XOR of all 16 bits of spi_rx_data is 0 (even parity) and bit 14 (sensor error) is 0.
  - Good reply: on the next cycle, sample_valid=1, cycle[idx]=1, and sample_index/sample_angle are updated.
  - Bad reply: error_flags[idx] is set; no strobe.
- Timeout: error_flags[idx] is set; no strobe; move to DESELECT; a late spi_done is ignored.
- spi_done outside WAIT is ignored.
- frame_tick while busy: frame_overrun is set and the tick is dropped. The current frame continues.
- frame_tick with a latched mask of 0: stay IDLE; not an overrun.
- enable_mask changes mid-frame have no effect until the next frame.
- Error flag set and clear_errors in the same cycle: set wins.
- Reset:
  - FSM to IDLE; frame counter to 0.
  - ss_n all ones.
  - spi_start, sample_valid, cycle, busy to 0.
  - sample_index, sample_angle, error_flags, frame_overrun to 0.
  - spi_tx_data = READ_CMD.
- Reset mid-transfer: ss_n goes high at the next edge.

## Timing
- All outputs are registered.
- Tick at cycle T, first sensor:
  - ss_n low from T+1.
  - spi_start at T+1+SETUP_CYCLES.
- spi_done at cycle D: sample_valid and cycle at D+1; ss_n high from D+1.
- Next sensor: ss_n low at D+1+GAP_CYCLES+1 (one cycle in NEXT).
- Timeout: if spi_start is at S and no done arrives, the error flag is set and ss_n goes high at S+1+TIMEOUT_CYCLES.
- First frame_tick occurs PERIOD-1 cycles after reset deasserts (count 0 on the first clock out of reset).

## Test plan
Bench parameters: CLOCK_SPEED_HZ=1000, UPDATE_RATE_HZ=10 (PERIOD=100), TIMEOUT_CYCLES=32.
- Mask 6'b000101, SPI model returns 16'h0123 (even parity) 10 cycles after start -> per frame, exactly two strobes: cycle=000001 with angle 0x123, then cycle=000100 with index 2. No other ss_n bit goes low.
- Reply 16'h0122 (odd parity) for sensor 0 -> error_flags[0]=1, no sample_valid. Then clear_errors -> flag returns to 0.
- Reply 16'h4123 with parity fixed (16'hC123) -> error_flags[idx]=1 via bit 14.
- spi_done never arrives -> error_flag set exactly 33 cycles after spi_start. The next sensor is still polled. A late spi_done produces no strobe.
- Model delay 60 cycles, 6 sensors enabled -> frame_overrun=1. No new frame starts until IDLE; polling resumes at the following tick.
- reset asserted during WAIT -> next edge: ss_n=6'b111111, busy=0, error_flags=0. Mask 0 -> no spi_start for 3 frames.
